// File: rtl/sr_reg_checker_if.sv
// Debug-port and expected-table bundle for sr_reg_checker.
// exp_mask exists only when SR_REG_CHECKER_MASK_EN is defined.
interface sr_reg_checker_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_CHECKS = 22
);
  localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic [REG_ADDR_W-1:0] regAddr;
  logic [XLEN-1:0]       regData;
  logic [IW-1:0]         chk_idx;
  logic [REG_ADDR_W-1:0] exp_addr;
  logic [XLEN-1:0]       exp_data;
`ifdef SR_REG_CHECKER_MASK_EN
  logic [XLEN-1:0]       exp_mask;

  modport master (
    output regAddr, chk_idx,
    input  regData, exp_addr, exp_data, exp_mask
  );
  modport slave (
    input  regAddr, chk_idx,
    output regData, exp_addr, exp_data, exp_mask
  );
`else
  modport master (
    output regAddr, chk_idx,
    input  regData, exp_addr, exp_data
  );
  modport slave (
    input  regAddr, chk_idx,
    output regData, exp_addr, exp_data
  );
`endif
endinterface

// File: rtl/sr_reg_checker.sv
// Register-file self-check engine: settle, scan, compare, report.
// Define SR_REG_CHECKER_MASK_EN to compare under a per-entry exp_mask.
module sr_reg_checker #(
  parameter int XLEN         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_CHECKS   = 22,
  parameter int WAIT_CYCLES  = 50,
  parameter int READ_LATENCY = 0,
  localparam int IW  = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int ECW = $clog2(NUM_CHECKS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  sr_reg_checker_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ECW-1:0]  err_count,
  output logic [IW-1:0]   fail_idx,
  output logic [XLEN-1:0] fail_data
);

  localparam int WCW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SCAN,
    DONE
  } state_t;

  localparam state_t StartState =
    (WAIT_CYCLES > 0) ? WAIT : SCAN;

  state_t          state;
  logic [WCW-1:0]  waitCnt;
  logic [IW-1:0]   idx;
  logic            phase;
  logic            drain;
  logic            cmpValid;
  logic            cmpMis;
  logic [IW-1:0]   cmpIdx;
  logic [XLEN-1:0] cmpData;
  logic            mismatch;
  logic            sampleNow;
  logic            lastIdx;
  logic [ECW-1:0]  errNext;

  always_comb begin
    mismatch = 1'b0;
`ifdef SR_REG_CHECKER_MASK_EN
    mismatch =
      |((bus.regData ^ bus.exp_data) & bus.exp_mask);
`else
    mismatch = bus.regData != bus.exp_data;
`endif
  end

  assign sampleNow = phase == 1'(READ_LATENCY);
  assign lastIdx   = idx == IW'(NUM_CHECKS - 1);
  assign errNext   =
    err_count + ECW'(cmpValid & cmpMis);

  assign bus.chk_idx = idx;
  assign bus.regAddr =
    (state == SCAN) ? bus.exp_addr : '0;

  // Compares are registered and retire one edge later;
  // the drain cycle lets the last one land before DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      waitCnt   <= '0;
      idx       <= '0;
      phase     <= 1'b0;
      drain     <= 1'b0;
      cmpValid  <= 1'b0;
      cmpMis    <= 1'b0;
      cmpIdx    <= '0;
      cmpData   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= '0;
      fail_data <= '0;
    end else begin
      cmpValid <= 1'b0;
      if (cmpValid && cmpMis) begin
        err_count <= errNext;
        if (err_count == '0) begin
          fail_idx  <= cmpIdx;
          fail_data <= cmpData;
        end
      end
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= StartState;
            waitCnt   <= WCW'(WAIT_CYCLES);
            idx       <= '0;
            phase     <= 1'b0;
            drain     <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_idx  <= '0;
            fail_data <= '0;
          end
        end
        WAIT: begin
          waitCnt <= waitCnt - 1'b1;
          if (waitCnt == WCW'(1)) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (drain) begin
            state <= DONE;
            drain <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= errNext == '0;
          end else if (sampleNow) begin
            cmpValid <= 1'b1;
            cmpMis   <= mismatch;
            cmpIdx   <= idx;
            cmpData  <= bus.regData;
            phase    <= 1'b0;
            if (lastIdx) begin
              drain <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_reg_checker.sv
// Bench: DUT0 (wait 50, latency 0) and DUT1 (wait 0, latency 1)
// against a cycle-count/table model plus literal expectations.
module tb_sr_reg_checker;

  localparam int N = 22;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        startV    [2];
  logic        busyV     [2];
  logic        doneV     [2];
  logic        passV     [2];
  logic [4:0]  errV      [2];
  logic [4:0]  failIdxV  [2];
  logic [31:0] failDataV [2];
  logic [4:0]  regAddrV  [2];
  logic [4:0]  chkIdxV   [2];

  logic [31:0] rf      [2][32];
  logic [4:0]  expAddr [32];
  logic [31:0] expData [32];
`ifdef SR_REG_CHECKER_MASK_EN
  logic [31:0] expMask [32];
`endif
  logic [31:0] rd1;

  int vectors = 0;
  int miscompares = 0;

  sr_reg_checker_if #(.XLEN(32), .REG_ADDR_W(5), .NUM_CHECKS(N)) bus0 ();
  sr_reg_checker_if #(.XLEN(32), .REG_ADDR_W(5), .NUM_CHECKS(N)) bus1 ();

  assign bus0.regData  = rf[0][bus0.regAddr];
  assign bus0.exp_addr = expAddr[bus0.chk_idx];
  assign bus0.exp_data = expData[bus0.chk_idx];
  assign bus1.regData  = rd1;
  assign bus1.exp_addr = expAddr[bus1.chk_idx];
  assign bus1.exp_data = expData[bus1.chk_idx];
`ifdef SR_REG_CHECKER_MASK_EN
  assign bus0.exp_mask = expMask[bus0.chk_idx];
  assign bus1.exp_mask = expMask[bus1.chk_idx];
`endif
  assign regAddrV[0] = bus0.regAddr;
  assign regAddrV[1] = bus1.regAddr;
  assign chkIdxV[0]  = bus0.chk_idx;
  assign chkIdxV[1]  = bus1.chk_idx;

  always @(posedge clk) rd1 <= rf[1][bus1.regAddr];

  sr_reg_checker #(
    .XLEN(32), .REG_ADDR_W(5), .NUM_CHECKS(N),
    .WAIT_CYCLES(50), .READ_LATENCY(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]), .bus(bus0),
    .busy(busyV[0]), .done(doneV[0]), .pass(passV[0]),
    .err_count(errV[0]), .fail_idx(failIdxV[0]),
    .fail_data(failDataV[0])
  );

  sr_reg_checker #(
    .XLEN(32), .REG_ADDR_W(5), .NUM_CHECKS(N),
    .WAIT_CYCLES(0), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]), .bus(bus1),
    .busy(busyV[1]), .done(doneV[1]), .pass(passV[1]),
    .err_count(errV[1]), .fail_idx(failIdxV[1]),
    .fail_data(failDataV[1])
  );

  localparam logic [31:0] ZBB [N] = '{
    32'hB92F04A1, 32'h00000020, 32'hB90304A1, 32'h0000000C,
    32'h4A1B92F0, 32'h04A1B92F, 32'hA1B92F04, 32'h00000003,
    32'hFFFFFFE0, 32'h2F04A1B9, 32'h000000B9, 32'h0000002F,
    32'h000004A1, 32'hFFFFB92F, 32'h00000001, 32'hB92F0000,
    32'h12345A5A, 32'h0F0F0F0F, 32'h5A5A1234, 32'h00000018,
    32'hFFFFFFFF, 32'hA1042FB9
  };

  function automatic int wOf(int d);
    return (d == 0) ? 50 : 0;
  endfunction

  function automatic int lOf(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int tOf(int d);
    return wOf(d) + N * (lOf(d) + 1) + 1;
  endfunction

  // Result the table rules demand: {errCount, firstIdx, firstData}.
  function automatic logic [47:0] calc(int d);
    int e = 0;
    int fi = 0;
    logic [31:0] fd = '0;
    logic [31:0] got;
    logic [31:0] m;
    for (int i = 0; i < N; i++) begin
      got = rf[d][expAddr[i]];
      m = '1;
`ifdef SR_REG_CHECKER_MASK_EN
      m = expMask[i];
`endif
      if (((got ^ expData[i]) & m) != 0) begin
        if (e == 0) begin
          fi = i;
          fd = got;
        end
        e++;
      end
    end
    return {8'(e), 8'(fi), fd};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  bit          act [2];
  int          cyc [2];
  logic [47:0] res [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        act[d] <= 1'b0;
        cyc[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (startV[d] && !(act[d] && cyc[d] < tOf(d))) begin
          act[d] <= 1'b1;
          cyc[d] <= 0;
        end else if (act[d] && cyc[d] < 1000) begin
          cyc[d] <= cyc[d] + 1;
          if (cyc[d] + 1 == tOf(d)) res[d] <= calc(d);
        end
      end
    end
  end

  int cw, ct, ck, cix;
  bit cScan, cDone;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!act[d]) begin
        chk($sformatf("d%0d_rst_busy", d), 64'(busyV[d]), 0);
        chk($sformatf("d%0d_rst_done", d), 64'(doneV[d]), 0);
        chk($sformatf("d%0d_rst_pass", d), 64'(passV[d]), 0);
        chk($sformatf("d%0d_rst_err", d), 64'(errV[d]), 0);
        chk($sformatf("d%0d_rst_fidx", d), 64'(failIdxV[d]), 0);
        chk($sformatf("d%0d_rst_fdata", d), 64'(failDataV[d]), 0);
        chk($sformatf("d%0d_rst_addr", d), 64'(regAddrV[d]), 0);
        chk($sformatf("d%0d_rst_idx", d), 64'(chkIdxV[d]), 0);
      end else begin
        cw = wOf(d);
        ct = tOf(d);
        ck = cyc[d];
        cScan = ck >= cw && ck < ct;
        cDone = ck >= ct;
        cix = cScan ? (ck - cw) / (lOf(d) + 1) : 0;
        if (cix > N - 1) cix = N - 1;
        chk($sformatf("d%0d_busy", d), 64'(busyV[d]), 64'(!cDone));
        chk($sformatf("d%0d_done", d), 64'(doneV[d]), 64'(cDone));
        chk($sformatf("d%0d_pass", d), 64'(passV[d]),
            64'(cDone && res[d][47:40] == 0));
        chk($sformatf("d%0d_addr", d), 64'(regAddrV[d]),
            cScan ? 64'(expAddr[cix]) : 64'd0);
        if (cScan)
          chk($sformatf("d%0d_idx", d), 64'(chkIdxV[d]), 64'(cix));
        if (cDone) begin
          chk($sformatf("d%0d_err", d), 64'(errV[d]),
              64'(res[d][47:40]));
          chk($sformatf("d%0d_fidx", d), 64'(failIdxV[d]),
              64'(res[d][39:32]));
          chk($sformatf("d%0d_fdata", d), 64'(failDataV[d]),
              64'(res[d][31:0]));
        end
      end
    end
  end

  task automatic loadRf(int d);
    for (int i = 0; i < 32; i++) rf[d][i] = '0;
    for (int i = 0; i < N; i++) rf[d][i+1] = ZBB[i];
  endtask

  task automatic runDut(int d, int retrigAt, output int n);
    @(negedge clk);
    startV[d] = 1'b1;
    @(posedge clk);
    #1;
    startV[d] = 1'b0;
    chk($sformatf("d%0d_busy_after_start", d), 64'(busyV[d]), 1);
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      startV[d] = (n == retrigAt);
      if (doneV[d]) break;
    end
    startV[d] = 1'b0;
    if (!doneV[d]) chk($sformatf("d%0d_done_timeout", d), 0, 1);
  endtask

  int n;

  initial begin
    startV[0] = 1'b0;
    startV[1] = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expAddr[i] = 5'((i < N) ? i + 1 : 0);
      expData[i] = (i < N) ? ZBB[i] : 32'h0;
`ifdef SR_REG_CHECKER_MASK_EN
      expMask[i] = '1;
`endif
    end
    loadRf(0);
    loadRf(1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_done", 64'(doneV[0]), 0);
    chk("reset_err", 64'(errV[0]), 0);

    runDut(0, -1, n);
    chk("allmatch_edge", 64'(n), 73);
    chk("allmatch_pass", 64'(passV[0]), 1);
    chk("allmatch_err", 64'(errV[0]), 0);

    rf[0][3] = 32'hB90304A0;
    runDut(0, -1, n);
    chk("single_edge", 64'(n), 73);
    chk("single_pass", 64'(passV[0]), 0);
    chk("single_err", 64'(errV[0]), 1);
    chk("single_fidx", 64'(failIdxV[0]), 2);
    chk("single_fdata", 64'(failDataV[0]), 64'h0B90304A0);

    loadRf(0);
    rf[0][6]  = 32'hDEADBEEF;
    rf[0][18] = 32'h12345678;
    runDut(0, -1, n);
    chk("multi_err", 64'(errV[0]), 2);
    chk("multi_fidx", 64'(failIdxV[0]), 5);
    chk("multi_fdata", 64'(failDataV[0]), 64'h0DEADBEEF);
    loadRf(0);
    runDut(0, -1, n);
    chk("rerun_pass", 64'(passV[0]), 1);
    chk("rerun_err", 64'(errV[0]), 0);

    runDut(1, -1, n);
    chk("lat1_edge", 64'(n), 45);
    chk("lat1_pass", 64'(passV[1]), 1);
    chk("lat1_err", 64'(errV[1]), 0);

    rf[0][4] = 32'h0;
    @(negedge clk);
    startV[0] = 1'b1;
    @(posedge clk);
    #1;
    startV[0] = 1'b0;
    n = 0;
    while (chkIdxV[0] != 5'd10 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("midscan_reached", 64'(chkIdxV[0]), 10);
    chk("midscan_err", 64'(errV[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busyV[0]), 0);
    chk("arst_err", 64'(errV[0]), 0);
    chk("arst_fidx", 64'(failIdxV[0]), 0);
    chk("arst_fdata", 64'(failDataV[0]), 0);
    chk("arst_addr", 64'(regAddrV[0]), 0);
    chk("arst_idx", 64'(chkIdxV[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    loadRf(0);
    runDut(0, 10, n);
    chk("retrig_edge", 64'(n), 73);
    chk("retrig_pass", 64'(passV[0]), 1);

`ifdef SR_REG_CHECKER_MASK_EN
    expData[0] = 32'h000004A1;
    expMask[0] = 32'h0000FFFF;
    rf[0][1]   = 32'hFFFF04A1;
    runDut(0, -1, n);
    chk("mask_pass", 64'(passV[0]), 1);
    chk("mask_err", 64'(errV[0]), 0);
    expMask[0] = 32'hFFFFFFFF;
    runDut(0, -1, n);
    chk("nomask_err", 64'(errV[0]), 1);
    chk("nomask_fdata", 64'(failDataV[0]), 64'h0FFFF04A1);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
